two_dev_bus_arbiter: RTL and testbench

Sequential arbiter and transfer controller for the two-device shared bus. It turns per-device requests into a registered one-hot grant and the bus `sel` line, with round-robin fairness and a bounded burst length. Each accepted beat is captured into a registered bus word and flagged to every reader with a one-cycle valid strobe. It sits in front of the 2-to-1 bus multiplexer and replaces a free-running `sel` with request/grant control.

---
 rtl/two_dev_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_two_dev_bus_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/two_dev_bus_arbiter.sv
// Round-robin arbiter and beat capture for the two-device shared bus.
// Produces registered one-hot grants, the mux select, and a registered bus word with a valid strobe.
module two_dev_bus_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_1,
    input  logic         req_2,
    input  logic [N-1:0] data_in_1,
    input  logic [N-1:0] data_in_2,
    input  logic         bus_ready,
    output logic         gnt_1,
    output logic         gnt_2,
    output logic         sel,
    output logic [N-1:0] bus,
    output logic         bus_valid,
    output logic [N-1:0] data_out_1,
    output logic [N-1:0] data_out_2
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t       state_q, state_d;
    logic [7:0]   beat_cnt_q, beat_cnt_d;
    logic         last2_q, last2_d;      // 1: device 2 held the bus most recently
    logic         gnt1_q, gnt1_d;
    logic         gnt2_q, gnt2_d;
    logic         sel_q, sel_d;
    logic [N-1:0] bus_q, bus_d;
    logic         valid_q, valid_d;

    logic         own_req;
    logic         oth_req;
    logic [N-1:0] own_data;
    logic         accept;
    logic [7:0]   cnt_next;
    state_t       other_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            last2_q    <= 1'b1;
            gnt1_q     <= 1'b0;
            gnt2_q     <= 1'b0;
            sel_q      <= 1'b0;
            bus_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            last2_q    <= last2_d;
            gnt1_q     <= gnt1_d;
            gnt2_q     <= gnt2_d;
            sel_q      <= sel_d;
            bus_q      <= bus_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        last2_d     = last2_q;
        bus_d       = bus_q;
        valid_d     = 1'b0;
        own_req     = 1'b0;
        oth_req     = 1'b0;
        own_data    = '0;
        accept      = 1'b0;
        cnt_next    = beat_cnt_q;
        other_state = IDLE;

        unique case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                if (req_1 && (!req_2 || last2_q)) begin
                    state_d = OWN1;
                end else if (req_2) begin
                    state_d = OWN2;
                end
            end
            OWN1, OWN2: begin
                own_req     = (state_q == OWN1) ? req_1 : req_2;
                oth_req     = (state_q == OWN1) ? req_2 : req_1;
                own_data    = (state_q == OWN1) ? data_in_1 : data_in_2;
                other_state = (state_q == OWN1) ? OWN2 : OWN1;
                accept      = own_req & bus_ready;
                cnt_next    = beat_cnt_q + {7'd0, accept};

                if (accept) begin
                    bus_d   = own_data;
                    valid_d = 1'b1;
                end

                // Exit/limit decisions use the count including this cycle's beat.
                if (!own_req || (cnt_next == HOLD_LIM)) begin
                    beat_cnt_d = '0;
                    if (oth_req) begin
                        state_d = other_state;
                        last2_d = (state_q == OWN2);
                    end else if (!own_req) begin
                        state_d = IDLE;
                        last2_d = (state_q == OWN2);
                    end
                end else begin
                    beat_cnt_d = cnt_next;
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase

        gnt1_d = (state_d == OWN1);
        gnt2_d = (state_d == OWN2);
        unique case (state_d)
            OWN1:    sel_d = 1'b0;
            OWN2:    sel_d = 1'b1;
            default: sel_d = sel_q;
        endcase
    end

    assign gnt_1      = gnt1_q;
    assign gnt_2      = gnt2_q;
    assign sel        = sel_q;
    assign bus        = bus_q;
    assign bus_valid  = valid_q;
    assign data_out_1 = bus_q;
    assign data_out_2 = bus_q;

endmodule

// File: tb/tb_two_dev_bus_arbiter.sv
// Vector-table bench for two_dev_bus_arbiter with a scoreboard for accepted bus beats.
module tb_two_dev_bus_arbiter;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_1 = 1'b0;
    logic         req_2 = 1'b0;
    logic [N-1:0] data_in_1 = '0;
    logic [N-1:0] data_in_2 = '0;
    logic         bus_ready = 1'b0;
    logic         gnt_1, gnt_2, sel, bus_valid;
    logic [N-1:0] bus, data_out_1, data_out_2;

    two_dev_bus_arbiter #(.N(N), .HOLD_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_1      (req_1),
        .req_2      (req_2),
        .data_in_1  (data_in_1),
        .data_in_2  (data_in_2),
        .bus_ready  (bus_ready),
        .gnt_1      (gnt_1),
        .gnt_2      (gnt_2),
        .sel        (sel),
        .bus        (bus),
        .bus_valid  (bus_valid),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2)
    );

    always #5 clk = ~clk;

    // acc: which device's beat is accepted at the edge ending this row (0 = none).
    // g1/g2/s: grant and select values expected just after that edge.
    typedef struct {
        logic         rs;
        logic         r1;
        logic         r2;
        logic         rdy;
        logic [N-1:0] d1;
        logic [N-1:0] d2;
        int unsigned  acc;
        logic         g1;
        logic         g2;
        logic         s;
    } vec_t;

    vec_t         vecs[$];
    logic [N-1:0] sb[$];
    logic [N-1:0] last_bus;
    int           checks = 0;
    int           errors = 0;
    int           pushes = 0;
    int           pops = 0;

    function automatic void add(input logic r1, input logic r2, input logic rdy,
                                input logic [N-1:0] d1, input logic [N-1:0] d2,
                                input int unsigned acc,
                                input logic g1, input logic g2, input logic s);
        vec_t v;
        v.rs = 1'b0; v.r1 = r1; v.r2 = r2; v.rdy = rdy; v.d1 = d1; v.d2 = d2;
        v.acc = acc; v.g1 = g1; v.g2 = g2; v.s = s;
        vecs.push_back(v);
    endfunction

    function automatic void add_rst();
        vec_t v;
        v.rs = 1'b1; v.r1 = 1'b0; v.r2 = 1'b0; v.rdy = 1'b0; v.d1 = '0; v.d2 = '0;
        v.acc = 0; v.g1 = 1'b0; v.g2 = 1'b0; v.s = 1'b0;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_1 = 1'b0; req_2 = 1'b0; bus_ready = 1'b0;
        data_in_1 = '0; data_in_2 = '0;
        rst = 1'b1;
        #1;
        chk("rst_gnt_1", 32'(gnt_1), 32'd0);
        chk("rst_gnt_2", 32'(gnt_2), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_bus", 32'(bus), 32'd0);
        chk("rst_valid", 32'(bus_valid), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        last_bus = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        logic [N-1:0] exp_bus;
        @(negedge clk);
        req_1 = v.r1; req_2 = v.r2; bus_ready = v.rdy;
        data_in_1 = v.d1; data_in_2 = v.d2;
        if (v.acc == 1) begin sb.push_back(v.d1); pushes++; end
        else if (v.acc == 2) begin sb.push_back(v.d2); pushes++; end
        @(posedge clk);
        #1;
        chk("gnt_1", 32'(gnt_1), 32'(v.g1));
        chk("gnt_2", 32'(gnt_2), 32'(v.g2));
        chk("sel", 32'(sel), 32'(v.s));
        chk("bus_valid", 32'(bus_valid), 32'(v.acc != 0));
        if (bus_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(bus), 32'hFFFF_FFFF);
            end else begin
                exp_bus = sb.pop_front();
                pops++;
                chk("bus_beat", 32'(bus), 32'(exp_bus));
                last_bus = exp_bus;
            end
        end else begin
            chk("bus_hold", 32'(bus), 32'(last_bus));
        end
        chk("data_out_1", 32'(data_out_1), 32'(last_bus));
        chk("data_out_2", 32'(data_out_2), 32'(last_bus));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        last_bus = '0;

        // Single requester, first beat latency
        add_rst();
        add(1, 0, 1, 8'hA5, 8'h00, 0, 1, 0, 0);
        add(1, 0, 1, 8'hA5, 8'h00, 1, 1, 0, 0);
        add(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);

        // Tie from reset, early release handover, sel holds in IDLE
        add_rst();
        add(1, 1, 1, 8'h11, 8'h21, 0, 1, 0, 0);
        add(1, 1, 1, 8'h12, 8'h22, 1, 1, 0, 0);
        add(1, 1, 1, 8'h13, 8'h23, 1, 1, 0, 0);
        add(0, 1, 1, 8'h14, 8'h24, 0, 0, 1, 1);
        add(0, 1, 1, 8'h15, 8'h25, 2, 0, 1, 1);
        add(0, 0, 1, 8'h16, 8'h26, 0, 0, 0, 1);

        // Continuous contention: 4/4 alternation with no gaps
        add_rst();
        add(1, 1, 1, 8'h3F, 8'hBF, 0, 1, 0, 0);
        for (int k = 0; k < 12; k++) begin
            int unsigned owner;
            int unsigned after;
            owner = ((k / 4) % 2 == 0) ? 1 : 2;
            after = (k % 4 == 3) ? 3 - owner : owner;
            add(1, 1, 1, 8'(8'h40 + k), 8'(8'hC0 + k), owner,
                after == 1, after == 2, after == 2);
        end
        add(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 1);

        // bus_ready toggling: limit counts accepted beats, not cycles
        add_rst();
        add(1, 1, 1, 8'h50, 8'hD0, 0, 1, 0, 0);
        for (int k = 0; k < 7; k++) begin
            logic rdy;
            rdy = (k % 2 == 0);
            add(1, 1, rdy, 8'(8'h51 + k), 8'(8'hD1 + k), rdy ? 1 : 0,
                k != 6, k == 6, k == 6);
        end
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1);

        // Lone requester keeps the grant past HOLD_MAX
        add_rst();
        add(0, 1, 1, 8'h00, 8'hDF, 0, 0, 1, 1);
        for (int k = 0; k < 10; k++) begin
            add(0, 1, 1, 8'(8'h60 + k), 8'(8'hE0 + k), 2, 0, 1, 1);
        end
        add(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rs) do_reset();
            else apply(vecs[i]);
        end
        chk("beats_delivered", 32'(pops), 32'(pushes));

        // Asynchronous reset during a burst, then tie goes to device 1
        do_reset();
        @(negedge clk);
        req_2 = 1'b1; bus_ready = 1'b1; data_in_2 = 8'h30;
        @(posedge clk); #1;
        chk("r6_gnt_2", 32'(gnt_2), 32'd1);
        @(negedge clk);
        data_in_2 = 8'h31;
        @(posedge clk); #1;
        chk("r6_beat1", 32'(bus), 32'h31);
        @(negedge clk);
        data_in_2 = 8'h32;
        @(posedge clk); #1;
        chk("r6_beat2", 32'(bus), 32'h32);
        chk("r6_valid_pre", 32'(bus_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("r6_gnt_2_async", 32'(gnt_2), 32'd0);
        chk("r6_gnt_1_async", 32'(gnt_1), 32'd0);
        chk("r6_sel_async", 32'(sel), 32'd0);
        chk("r6_bus_async", 32'(bus), 32'd0);
        chk("r6_valid_async", 32'(bus_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_1 = 1'b1; req_2 = 1'b1; data_in_1 = 8'h5A; data_in_2 = 8'hA5;
        @(posedge clk); #1;
        chk("r6_tie_gnt_1", 32'(gnt_1), 32'd1);
        chk("r6_tie_gnt_2", 32'(gnt_2), 32'd0);
        chk("r6_tie_sel", 32'(sel), 32'd0);
        @(posedge clk); #1;
        chk("r6_tie_bus", 32'(bus), 32'h5A);
        chk("r6_tie_valid", 32'(bus_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
